// File: rtl/matrix_pkg.sv
// matrix_pkg: drain FSM states and the width helper shared by the fetch and drain blocks
package matrix_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, DRAIN, FLUSH} drain_state_t;
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lane_writer.sv
// lane_writer: one bank's address counter and registered write port, optional ReLU under MATRIX_DRAIN_RELU_EN
module lane_writer import matrix_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int INTER_NUM  = 8,
  parameter int ADDR_WIDTH = width_of(INTER_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  vld,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] d;
`ifdef MATRIX_DRAIN_RELU_EN
  assign d = din[DATA_WIDTH-1] ? '0 : din;
`else
  assign d = din;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= vld;
      if (vld) begin
        wr_addr <= ptr;
        wr_data <= d;
      end
      ptr <= clr ? '0 : !vld ? ptr : (ptr == ADDR_WIDTH'(INTER_NUM - 1)) ? '0 : ptr + ADDR_WIDTH'(1);
    end
  end
endmodule

// File: rtl/matrix_drain.sv
// matrix_drain: un-skews systolic result rows into per-lane banks; ReLU option via MATRIX_DRAIN_RELU_EN
module matrix_drain import matrix_pkg::*; #(
  parameter int DATA_WIDTH   = 8,
  parameter int PARALLEL_NUM = 8,
  parameter int INTER_NUM    = 8,
  parameter int ADDR_WIDTH   = width_of(INTER_NUM)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en_drain,
  input  logic                                    row_valid_i,
  input  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] row_i,
  output logic [PARALLEL_NUM-1:0]                 wr_en_o,
  output logic [PARALLEL_NUM-1:0][ADDR_WIDTH-1:0] wr_addr_o,
  output logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] wr_data_o,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    ovf_o
);
  localparam int CW = width_of(INTER_NUM + 1);
  localparam int FW = width_of(PARALLEL_NUM);
  drain_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fc;
  logic [PARALLEL_NUM-1:1] vld_q;
  logic [PARALLEL_NUM-1:0] vld;
  logic acc, arm, last, flush_end;
  assign acc       = row_valid_i && (state == ARMED || state == DRAIN) && cnt < CW'(INTER_NUM);
  assign arm       = state == IDLE && en_drain;
  assign last      = acc && cnt == CW'(INTER_NUM - 1);
  assign flush_end = state == FLUSH && fc == FW'(PARALLEL_NUM - 1);
  assign vld       = {vld_q, acc};
  assign busy_o    = state != IDLE;
  always_comb begin
    state_n = state;
    state_n = arm ? ARMED : last ? FLUSH : (state == ARMED && acc) ? DRAIN : flush_end ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      fc     <= '0;
      vld_q  <= '0;
      done_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= arm ? '0 : cnt + CW'(acc);
      fc     <= (state == FLUSH) ? fc + FW'(1) : '0;
      vld_q  <= vld[PARALLEL_NUM-2:0];
      done_o <= flush_end;
      ovf_o  <= arm ? 1'b0 : ovf_o | (state == FLUSH && row_valid_i);
    end
  end
  // lane k sees the accept k cycles late, matching its skewed data
  for (genvar k = 0; k < PARALLEL_NUM; k++) begin : g_lane
    lane_writer #(
      .DATA_WIDTH(DATA_WIDTH),
      .INTER_NUM (INTER_NUM),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (arm),
      .vld    (vld[k]),
      .din    (row_i[k]),
      .wr_en  (wr_en_o[k]),
      .wr_addr(wr_addr_o[k]),
      .wr_data(wr_data_o[k])
    );
  end
endmodule

// File: tb/tb_matrix_drain.sv
// tb_matrix_drain: table-driven and randomized checks of matrix_drain against a beat-schedule model
module tb_matrix_drain;
  localparam int P  = 4;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int L  = 80;

  logic clk = 1'b0;
  logic rst, en_drain, row_valid_i;
  logic [P-1:0][DW-1:0] row_i;
  logic [P-1:0] wr_en_o;
  logic [P-1:0][AW-1:0] wr_addr_o;
  logic [P-1:0][DW-1:0] wr_data_o;
  logic busy_o, done_o, ovf_o;

  matrix_drain #(.DATA_WIDTH(DW), .PARALLEL_NUM(P), .INTER_NUM(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .en_drain(en_drain), .row_valid_i(row_valid_i), .row_i(row_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] mask;
    bit          rnd;
    bit          en_mid;
    bit          f0;
    bit          exp_ovf;
    int          exp_writes;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit m_ovf = 0;
  logic [DW-1:0] bank [P][N];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef MATRIX_DRAIN_RELU_EN
    return x[DW-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat at offset o of mask is presented on lane 0 in cycle 1+o, lane k in 1+o+k.
  task automatic run_matrix(input logic [63:0] mask, input bit rnd, input bit en_mid, input bit f0,
                            output bit ovf_end, output int nwr);
    logic [P-1:0] e_en [L];
    logic [AW-1:0] e_addr [L][P];
    logic [DW-1:0] e_data [L][P];
    logic [DW-1:0] r [L][P];
    logic [DW-1:0] eb [P][N];
    bit e_done [L];
    bit e_busy [L];
    bit v [L];
    logic [DW-1:0] x;
    int j, c, t_last, len, ovf_start;
    for (int i = 0; i < L; i++) begin
      e_en[i] = '0; e_done[i] = 0; e_busy[i] = 0; v[i] = 0;
      for (int k = 0; k < P; k++) r[i][k] = DW'($urandom);
    end
    for (int k = 0; k < P; k++)
      for (int a = 0; a < N; a++) bank[k][a] = 'x;
    j = 0; t_last = 0; ovf_start = 1 << 30;
    for (int o = 0; o < 64; o++) begin
      if (mask[o]) begin
        c = 1 + o;
        v[c] = 1;
        for (int k = 0; k < P; k++) begin
          x = rnd ? DW'($urandom) : DW'(16 * j + k);
          if (f0 && j == 0 && k == 2) x = 8'hF0;
          r[c+k][k] = x;
          if (j < N) begin
            e_en[c+k+1][k] = 1'b1;
            e_addr[c+k+1][k] = AW'(j);
            e_data[c+k+1][k] = relu(x);
            eb[k][j] = relu(x);
          end
        end
        if (j == N - 1) t_last = c;
        if (j >= N && c > t_last && c <= t_last + P && c + 1 < ovf_start) ovf_start = c + 1;
        j++;
      end
    end
    for (int i = 1; i <= t_last + P; i++) e_busy[i] = 1;
    e_done[t_last + P + 1] = 1;
    len = t_last + P + 4;
    nwr = 0;
    for (int i = 0; i < len; i++) begin
      en_drain = (i == 0) || (en_mid && i == 4);
      row_valid_i = v[i];
      for (int k = 0; k < P; k++) row_i[k] = r[i][k];
      @(negedge clk);
      chk($sformatf("wr_en c%0d", i), 64'(wr_en_o), 64'(e_en[i]));
      for (int k = 0; k < P; k++) begin
        if (e_en[i][k]) begin
          chk($sformatf("addr c%0d l%0d", i, k), 64'(wr_addr_o[k]), 64'(e_addr[i][k]));
          chk($sformatf("data c%0d l%0d", i, k), 64'(wr_data_o[k]), 64'(e_data[i][k]));
        end
        if (wr_en_o[k]) begin
          nwr++;
          bank[k][wr_addr_o[k]] = wr_data_o[k];
        end
      end
      chk($sformatf("done c%0d", i), 64'(done_o), 64'(e_done[i]));
      chk($sformatf("busy c%0d", i), 64'(busy_o), 64'(e_busy[i]));
      chk($sformatf("ovf c%0d", i), 64'(ovf_o), 64'(i == 0 ? m_ovf : (i >= ovf_start)));
      tick();
    end
    en_drain = 0;
    row_valid_i = 0;
    for (int k = 0; k < P; k++)
      for (int a = 0; a < N; a++) chk($sformatf("bank%0d[%0d]", k, a), 64'(bank[k][a]), 64'(eb[k][a]));
    ovf_end = ovf_start < (1 << 30);
    m_ovf = ovf_end;
  endtask

  initial begin
    vec_t tbl [6];
    bit ovf_end;
    int nwr, nb, pos;
    logic [63:0] mask;
    logic [DW-1:0] relu_exp;
    tbl[0] = '{64'hFF,   0, 0, 0, 0, 32};
    tbl[1] = '{64'h4B8D, 0, 0, 0, 0, 32};
    tbl[2] = '{64'h1FF,  0, 0, 0, 1, 32};
    tbl[3] = '{64'hFF,   0, 1, 0, 0, 32};
    tbl[4] = '{64'h20FF, 0, 0, 0, 0, 32};
    tbl[5] = '{64'h3FF,  0, 0, 1, 1, 32};
`ifdef MATRIX_DRAIN_RELU_EN
    relu_exp = 8'h00;
`else
    relu_exp = 8'hF0;
`endif
    rst = 1; en_drain = 0; row_valid_i = 0; row_i = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst wr_en", 64'(wr_en_o), 0);
    chk("rst wr_addr", 64'(wr_addr_o), 0);
    chk("rst wr_data", 64'(wr_data_o), 0);
    chk("rst busy", 64'(busy_o), 0);
    chk("rst done", 64'(done_o), 0);
    chk("rst ovf", 64'(ovf_o), 0);
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      row_valid_i = (i < 3);
      row_i = {P{DW'($urandom)}};
      @(negedge clk);
      chk($sformatf("idle wr_en %0d", i), 64'(wr_en_o), 0);
      chk($sformatf("idle busy %0d", i), 64'(busy_o), 0);
      chk($sformatf("idle ovf %0d", i), 64'(ovf_o), 0);
      tick();
    end
    row_valid_i = 0;
    for (int t = 0; t < 6; t++) begin
      run_matrix(tbl[t].mask, tbl[t].rnd, tbl[t].en_mid, tbl[t].f0, ovf_end, nwr);
      chk($sformatf("vec%0d ovf", t), 64'(ovf_o), 64'(tbl[t].exp_ovf));
      chk($sformatf("vec%0d writes", t), 64'(nwr), 64'(tbl[t].exp_writes));
      if (tbl[t].f0) chk("relu lane2", 64'(bank[2][0]), 64'(relu_exp));
    end
    for (int t = 0; t < 8; t++) begin
      mask = '0; pos = 0;
      nb = 8 + $urandom_range(0, 2);
      for (int b = 0; b < nb; b++) begin
        mask[pos] = 1'b1;
        pos += 1 + $urandom_range(0, 2);
      end
      run_matrix(mask, 1, $urandom_range(0, 1) == 1, 0, ovf_end, nwr);
      chk($sformatf("rnd%0d ovf", t), 64'(ovf_o), 64'(ovf_end));
      chk($sformatf("rnd%0d writes", t), 64'(nwr), 64'(N * P));
    end
    en_drain = 1;
    tick();
    en_drain = 0;
    for (int i = 0; i < 3; i++) begin
      row_valid_i = 1;
      row_i = {P{DW'($urandom)}};
      tick();
    end
    row_valid_i = 0;
    rst = 1;
    @(negedge clk);
    chk("pre-rst wr_en", 64'(wr_en_o), 64'(4'b0111));
    tick();
    rst = 0;
    @(negedge clk);
    chk("midrst wr_en", 64'(wr_en_o), 0);
    chk("midrst wr_addr", 64'(wr_addr_o), 0);
    chk("midrst wr_data", 64'(wr_data_o), 0);
    chk("midrst busy", 64'(busy_o), 0);
    chk("midrst done", 64'(done_o), 0);
    chk("midrst ovf", 64'(ovf_o), 0);
    tick();
    m_ovf = 0;
    run_matrix(64'hFF, 0, 0, 0, ovf_end, nwr);
    chk("post-rst writes", 64'(nwr), 64'(N * P));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
